// File: rtl/uart_cmd_link_ctrl_pkg.sv
// Shared types and constants for the UART command link sequencer.
// Frame layout depends on UART_CMD_HAMMING_EN (see uart_cmd_link_ctrl).
package uart_cmd_link_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_TX_START,
    ST_TX_END,
    ST_WAIT_ACK,
    ST_RETRY
  } state_t;

  localparam logic [3:0] CMD_TURN_ON         = 4'h6;
  localparam logic [3:0] CMD_TURN_OFF        = 4'hD;
  localparam logic [7:0] ACK                 = 8'h3C;
  localparam logic [7:0] TOGGLE              = 8'h9D;
  localparam int         TIMEOUT_DEFAULT     = 48000;
  localparam int         MAX_RETRIES_DEFAULT = 3;

  // Plain framing: the complemented nibble in the upper half lets the receiver spot corruption.
  function automatic logic [7:0] frame_plain(input logic [3:0] code);
    return {~code, code};
  endfunction

endpackage

// File: rtl/uart_cmd_link_ctrl_hamming.sv
// Hamming(7,4) encoder: code = {d3, p2, d2, p1, d1, d0, p0}; 4'h6 encodes to 7'h1D.
module hamming_7_4_encoder (
  input  logic [3:0] data,
  output logic [6:0] code
);

  assign code = {data[3],
                 data[3] ^ data[2] ^ data[1],
                 data[2],
                 data[3] ^ data[2] ^ data[0],
                 data[1],
                 data[0],
                 data[3] ^ data[1] ^ data[0]};

endmodule

// File: rtl/uart_cmd_link_ctrl.sv
// Command/ack sequencer between master logic and uart_tx/uart_rx, with timeout and retries.
// Define UART_CMD_HAMMING_EN to frame commands as {1'b1, hamming_7_4(code)} instead of {~code, code}.
module uart_cmd_link_ctrl
  import uart_cmd_link_ctrl_pkg::*;
#(
  parameter logic [7:0] ACK_BYTE       = ACK,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int         MAX_RETRIES    = MAX_RETRIES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_code,
  output logic       cmd_ready,
  output logic       done,
  output logic       fail,
  output logic       busy,
  output logic [1:0] retry_cnt,
  output logic [7:0] data_to_tx,
  output logic       start_tx,
  input  logic       tx_busy,
  input  logic [7:0] data_received,
  input  logic       rx_done,
  input  logic       parity_error
);

  localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]   TIMER_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [1:0]      RETRY_LAST = 2'(MAX_RETRIES);

  state_t        state_reg;
  logic [TW-1:0] timer_reg;
  logic [7:0]    frame;
  logic          ack_ok;

`ifdef UART_CMD_HAMMING_EN
  logic [6:0] ham_code;

  hamming_7_4_encoder u_hamming (
    .data (cmd_code),
    .code (ham_code)
  );

  assign frame = {1'b1, ham_code};
`else
  assign frame = frame_plain(cmd_code);
`endif

  assign ack_ok = rx_done && !parity_error && (data_received == ACK_BYTE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      timer_reg  <= '0;
      cmd_ready  <= 1'b1;
      done       <= 1'b0;
      fail       <= 1'b0;
      busy       <= 1'b0;
      start_tx   <= 1'b0;
      retry_cnt  <= 2'd0;
      data_to_tx <= 8'h00;
    end else begin
      done     <= 1'b0;
      fail     <= 1'b0;
      start_tx <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // start_tx is raised on entry so it is high for exactly the SEND cycle
          if (cmd_valid && cmd_ready) begin
            data_to_tx <= frame;
            retry_cnt  <= 2'd0;
            start_tx   <= 1'b1;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            state_reg  <= ST_SEND;
          end
        end
        ST_SEND: state_reg <= ST_TX_START;
        ST_TX_START: begin
          if (tx_busy) state_reg <= ST_TX_END;
        end
        ST_TX_END: begin
          if (!tx_busy) begin
            timer_reg <= '0;
            state_reg <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (timer_reg != TIMER_MAX) timer_reg <= timer_reg + 1'b1;
          // a reply on the timeout cycle still counts as a reply
          if (rx_done) begin
            if (ack_ok) begin
              done      <= 1'b1;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              state_reg <= ST_IDLE;
            end else begin
              state_reg <= ST_RETRY;
            end
          end else if (timer_reg == TIMER_LAST) begin
            state_reg <= ST_RETRY;
          end
        end
        ST_RETRY: begin
          if (retry_cnt == RETRY_LAST) begin
            fail      <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            retry_cnt <= retry_cnt + 2'd1;
            start_tx  <= 1'b1;
            state_reg <= ST_SEND;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_link_ctrl.sv
// Self-checking bench for uart_cmd_link_ctrl: randomized ack/nack/silence scenarios vs. an attempt-level model.
`timescale 1ns/1ps
module tb_uart_cmd_link_ctrl;
  import uart_cmd_link_ctrl_pkg::*;

  localparam int         TO   = 100;
  localparam int         MAXR = 3;
  localparam logic [7:0] ACKB = 8'h3C;
  localparam logic [1:0] K_ACK = 2'd0, K_BAD = 2'd1, K_PAR = 2'd2, K_SIL = 2'd3;
`ifdef UART_CMD_HAMMING_EN
  localparam logic [7:0] TURN_ON_FRAME = 8'h9D;
`else
  localparam logic [7:0] TURN_ON_FRAME = 8'h96;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_code = 4'h0;
  logic       cmd_ready, done, fail, busy, start_tx;
  logic [1:0] retry_cnt;
  logic [7:0] data_to_tx;
  logic       tx_busy = 1'b0;
  logic [7:0] data_received = 8'h00;
  logic       rx_done = 1'b0;
  logic       parity_error = 1'b0;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, n_start = 0, n_done = 0, n_fail = 0;

  uart_cmd_link_ctrl #(.ACK_BYTE(ACKB), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MAXR)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_ready(cmd_ready), .done(done), .fail(fail), .busy(busy),
    .retry_cnt(retry_cnt), .data_to_tx(data_to_tx), .start_tx(start_tx),
    .tx_busy(tx_busy), .data_received(data_received), .rx_done(rx_done),
    .parity_error(parity_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (start_tx) n_start++;
    if (done) n_done++;
    if (fail) n_fail++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got cyc=%0d want finish", cyc);
    $fatal(1, "watchdog");
  end

  // Attempt-level model: the first attempt answered with a clean ack ends the command.
  function automatic void model(input logic [7:0] kinds, output int tries, output int outcome);
    tries = MAXR + 1;
    outcome = 1;
    for (int a = 0; a <= MAXR; a++) begin
      if (kinds[2*a +: 2] == K_ACK) begin
        tries = a + 1;
        outcome = 0;
        break;
      end
    end
  endfunction

  function automatic logic [7:0] exp_frame(input logic [3:0] c);
`ifdef UART_CMD_HAMMING_EN
    logic [6:0] w;
    exp_frame = 8'h00;
    // search the 7-bit space for the word with matching data bits and zero syndrome
    for (int v = 0; v < 128; v++) begin
      w = 7'(v);
      if ({w[6], w[4], w[2], w[1]} == c && (^{w[6], w[5], w[4], w[2]}) == 1'b0 &&
          (^{w[6], w[4], w[3], w[1]}) == 1'b0 && (^{w[6], w[2], w[1], w[0]}) == 1'b0)
        exp_frame = {1'b1, w};
    end
`else
    exp_frame = {~c, c};
`endif
  endfunction

  // Drives one command and plays uart_tx/uart_rx; outcome 0=done 1=fail 2=neither/both.
  task automatic run_cmd(input logic [3:0] code, input logic [7:0] kinds, input int ack_dly,
                         input bit inject, output int tries, output int outcome,
                         output int gap_min, output logic [7:0] frame0, output logic [7:0] frame_mid,
                         output bit lat_ok, output bit dlat_ok, output logic [1:0] rc);
    int s0, d0, f0, last, gap;
    bit found;
    logic [1:0] k;
    logic [7:0] bad;
    s0 = n_start; d0 = n_done; f0 = n_fail;
    gap_min = 1 << 30; dlat_ok = 1'b0; frame_mid = 8'h00;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_code = code;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat_ok = start_tx;
    frame0 = data_to_tx;
    last = cyc;
    for (int a = 0; a <= MAXR; a++) begin
      if (a > 0) begin
        found = 1'b0;
        for (int i = 0; i < 4*TO; i++) begin
          @(negedge clk);
          if (start_tx) begin found = 1'b1; break; end
          if (fail || done) break;
        end
        if (!found) break;
        gap = cyc - last;
        if (gap < gap_min) gap_min = gap;
        last = cyc;
      end
      repeat (2) @(negedge clk);
      tx_busy = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (inject && a == 0) begin
          cmd_valid = (i == 3);
          if (i == 3) cmd_code = ~code;
        end
      end
      tx_busy = 1'b0;
      frame_mid = data_to_tx;
      k = kinds[2*a +: 2];
      if (k != K_SIL) begin
        bad = 8'($urandom);
        if (bad == ACKB) bad = 8'h55;
        repeat (ack_dly) @(negedge clk);
        rx_done = 1'b1;
        parity_error = (k == K_PAR);
        data_received = (k == K_BAD) ? bad : ACKB;
        @(negedge clk);
        rx_done = 1'b0;
        parity_error = 1'b0;
        if (k == K_ACK) begin
          dlat_ok = done;
          break;
        end
      end
    end
    for (int i = 0; i < 4*TO && n_done == d0 && n_fail == f0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    tries = n_start - s0;
    if (n_done - d0 == 1 && n_fail == f0) outcome = 0;
    else if (n_fail - f0 == 1 && n_done == d0) outcome = 1;
    else outcome = 2;
    rc = retry_cnt;
    $display("txn code=%h kinds=%b dly=%0d tries=%0d outcome=%0d retry_cnt=%0d frame=%h",
             code, kinds, ack_dly, tries, outcome, rc, frame0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cmd_ready, done, fail, busy, start_tx, retry_cnt, data_to_tx} !== {5'b10000, 2'd0, 8'h00}) begin
      n_err++;
      $display("FAIL reset_values: got rdy=%b done=%b fail=%b busy=%b start=%b rc=%0d data=%h want 1 0 0 0 0 0 00",
               cmd_ready, done, fail, busy, start_tx, retry_cnt, data_to_tx);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_ack();
    int tries, outcome, gap; logic [7:0] f0, fm; bit lat, dlat; logic [1:0] rc;
    run_cmd(CMD_TURN_ON, 8'h00, 10, 1'b0, tries, outcome, gap, f0, fm, lat, dlat, rc);
    n_cmp++; if (tries !== 1) begin n_err++; $display("FAIL single_tries: got %0d want 1", tries); end
    n_cmp++; if (outcome !== 0) begin n_err++; $display("FAIL single_outcome: got %0d want 0", outcome); end
    n_cmp++; if (lat !== 1'b1) begin n_err++; $display("FAIL single_start_latency: got %b want 1", lat); end
    n_cmp++; if (dlat !== 1'b1) begin n_err++; $display("FAIL single_done_latency: got %b want 1", dlat); end
    n_cmp++; if (rc !== 2'd0) begin n_err++; $display("FAIL single_retry_cnt: got %0d want 0", rc); end
    n_cmp++; if (f0 !== TURN_ON_FRAME) begin n_err++; $display("FAIL single_frame: got %h want %h", f0, TURN_ON_FRAME); end
    n_cmp++; if ({cmd_ready, busy} !== 2'b10) begin n_err++; $display("FAIL single_idle: got rdy/busy=%b want 10", {cmd_ready, busy}); end
  endtask

  task automatic test_timeout();
    int tries, outcome, gap; logic [7:0] f0, fm; bit lat, dlat; logic [1:0] rc;
    run_cmd(CMD_TURN_OFF, 8'hFF, 10, 1'b0, tries, outcome, gap, f0, fm, lat, dlat, rc);
    n_cmp++; if (tries !== 4) begin n_err++; $display("FAIL timeout_tries: got %0d want 4", tries); end
    n_cmp++; if (outcome !== 1) begin n_err++; $display("FAIL timeout_outcome: got %0d want 1", outcome); end
    n_cmp++; if (rc !== 2'd3) begin n_err++; $display("FAIL timeout_retry_cnt: got %0d want 3", rc); end
    n_cmp++; if (gap < TO) begin n_err++; $display("FAIL timeout_gap: got %0d want >= %0d", gap, TO); end
    n_cmp++; if (f0 !== exp_frame(CMD_TURN_OFF)) begin n_err++; $display("FAIL timeout_frame: got %h want %h", f0, exp_frame(CMD_TURN_OFF)); end
  endtask

  task automatic test_nack_parity();
    int tries, outcome, gap; logic [7:0] f0, fm; bit lat, dlat; logic [1:0] rc;
    run_cmd(4'h3, {6'b0, K_BAD}, 15, 1'b0, tries, outcome, gap, f0, fm, lat, dlat, rc);
    n_cmp++; if ({tries, outcome, 30'(rc)} !== {32'd2, 32'd0, 30'd1}) begin
      n_err++; $display("FAIL nack_then_ack: got tries=%0d outcome=%0d rc=%0d want 2 0 1", tries, outcome, rc);
    end
    run_cmd(4'h9, {6'b0, K_PAR}, 15, 1'b0, tries, outcome, gap, f0, fm, lat, dlat, rc);
    n_cmp++; if ({tries, outcome, 30'(rc)} !== {32'd2, 32'd0, 30'd1}) begin
      n_err++; $display("FAIL parity_nack: got tries=%0d outcome=%0d rc=%0d want 2 0 1", tries, outcome, rc);
    end
    // reply lands exactly on the last timer cycle
    run_cmd(CMD_TURN_ON, 8'h00, TO, 1'b0, tries, outcome, gap, f0, fm, lat, dlat, rc);
    n_cmp++; if ({tries, outcome, 30'(rc)} !== {32'd1, 32'd0, 30'd0}) begin
      n_err++; $display("FAIL ack_on_timeout: got tries=%0d outcome=%0d rc=%0d want 1 0 0", tries, outcome, rc);
    end
  endtask

  task automatic test_reset_mid(input bit in_wait);
    int d0, f0, s0;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    @(negedge clk); cmd_valid = 1'b1; cmd_code = CMD_TURN_ON;
    @(negedge clk); cmd_valid = 1'b0;
    d0 = n_done; f0 = n_fail; s0 = n_start;
    repeat (2) @(negedge clk);
    tx_busy = 1'b1;
    repeat (5) @(negedge clk);
    if (in_wait) begin
      tx_busy = 1'b0;
      repeat (5) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, done, fail, busy, start_tx, retry_cnt, data_to_tx} !== {5'b10000, 2'd0, 8'h00}) begin
      n_err++;
      $display("FAIL reset_mid_%0d: got rdy=%b done=%b fail=%b busy=%b start=%b rc=%0d data=%h want 1 0 0 0 0 0 00",
               in_wait, cmd_ready, done, fail, busy, start_tx, retry_cnt, data_to_tx);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    tx_busy = 1'b0;
    // stale ack after the abort must not be taken
    rx_done = 1'b1; data_received = ACKB;
    @(negedge clk); rx_done = 1'b0;
    repeat (3*TO) @(negedge clk);
    n_cmp++;
    if ({n_done - d0, n_fail - f0, n_start - s0} !== {32'd0, 32'd0, 32'd0} || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_quiet_%0d: got done=%0d fail=%0d starts=%0d busy=%b want 0 0 0 0",
               in_wait, n_done - d0, n_fail - f0, n_start - s0, busy);
    end
  endtask

  task automatic test_drop_while_busy();
    int tries, outcome, gap; logic [7:0] f0, fm; bit lat, dlat; logic [1:0] rc;
    run_cmd(CMD_TURN_ON, 8'h00, 8, 1'b1, tries, outcome, gap, f0, fm, lat, dlat, rc);
    n_cmp++; if ({tries, outcome} !== {32'd1, 32'd0} || busy !== 1'b0) begin
      n_err++; $display("FAIL drop_while_busy: got tries=%0d outcome=%0d busy=%b want 1 0 0", tries, outcome, busy);
    end
    n_cmp++; if (fm !== TURN_ON_FRAME) begin n_err++; $display("FAIL drop_frame_stable: got %h want %h", fm, TURN_ON_FRAME); end
  endtask

  task automatic test_random();
    int tries, outcome, gap, et, eo; logic [7:0] f0, fm, kinds; bit lat, dlat; logic [1:0] rc; logic [3:0] code;
    for (int n = 0; n < 8; n++) begin
      code = 4'($urandom);
      kinds = 8'($urandom);
      model(kinds, et, eo);
      run_cmd(code, kinds, int'($urandom_range(1, TO)), 1'b0, tries, outcome, gap, f0, fm, lat, dlat, rc);
      n_cmp++;
      if (tries !== et || outcome !== eo || rc !== 2'(et - 1) || f0 !== exp_frame(code)) begin
        n_err++;
        $display("FAIL random_%0d: got tries=%0d outcome=%0d rc=%0d frame=%h want %0d %0d %0d %h",
                 n, tries, outcome, rc, f0, et, eo, et - 1, exp_frame(code));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_ack();
    test_timeout();
    test_nack_parity();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    test_drop_while_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
